mux_serializer_8b: RTL and testbench
====================================

MUX_SERIALIZER_8B -- requirements
Module: mux_serializer_8b

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0; 0 shifts bit 0 first, 1 shifts bit 7 first.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b0; this is the ser_out value when no frame is active.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream byte available.
REQ-006 SHALL have port in_data, input, 8 bits: byte to serialize.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a byte on this edge if in_valid is also high.
REQ-008 SHALL have port sel, output, 3 bits: current bit index driving the internal 8:1 mux.
REQ-009 SHALL have port ser_out, output, 1 bit: serial data bit.
REQ-010 SHALL have port ser_valid, output, 1 bit: ser_out carries a frame bit this cycle.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse during the last bit of a frame.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT.
REQ-013 SHALL accept a byte on any rising edge where in_valid=1 and in_ready=1, latching in_data into a hold register.
REQ-014 SHALL drive in_ready=1 in IDLE, and in SHIFT only when sel equals the last index (7 if MSB_FIRST=0, else 0).
REQ-015 Acceptance in IDLE SHALL cause a transition to SHIFT, with sel at the start index (0 if MSB_FIRST=0, else 7) in the next cycle.
REQ-016 In SHIFT, ser_out SHALL equal hold[sel] combinationally through the mux, and ser_valid SHALL be 1.
REQ-017 Latency: if a byte is accepted at edge N, bit k of the frame SHALL appear in cycle N+1+k, for k=0..7.
REQ-018 sel SHALL increment by 1 per cycle when MSB_FIRST=0 and decrement by 1 when MSB_FIRST=1, with no wrap inside a frame.
REQ-019 done SHALL be 1 exactly in the cycle sel equals the last index in SHIFT, and 0 otherwise.
REQ-020 Back-to-back: acceptance in the last-bit cycle SHALL reload hold, reset sel to the start index, and stay in SHIFT with no gap in ser_valid.
REQ-021 If the last-bit cycle has no acceptance, the FSM SHALL return to IDLE.
REQ-022 In IDLE, ser_out SHALL be IDLE_LEVEL, ser_valid=0, and sel SHALL hold the start index.
REQ-023 Changes to in_data or in_valid while in_ready=0 SHALL have no effect on hold, sel, or the outputs.

Reset
REQ-024 When rst=1 at an edge, the next cycle SHALL show: state IDLE, sel=start index, hold=8'h00, in_ready=1, ser_valid=0, done=0, ser_out=IDLE_LEVEL.
REQ-025 rst SHALL take priority over a simultaneous in_valid/in_ready acceptance; the byte is not accepted.
REQ-026 rst mid-frame SHALL abort the frame: no further bits are sent and no done pulse occurs.

Structure
REQ-027 Shared package mux_ser_pkg SHALL hold the state enum typedef (IDLE, SHIFT), DATA_W=8, and SEL_W=3.
REQ-028 The bit selection SHALL be done by one instance of the existing mux_8x1 (in=hold, sel=sel, out feeding ser_out), with no duplicated mux logic.
REQ-029 The implementation SHALL have no latches and one always_ff for state, sel, and hold.

Verification
REQ-030 Scenario LSB-first: MSB_FIRST=0, in_data=8'hA5 accepted at edge N -> ser_out 1,0,1,0,0,1,0,1 in cycles N+1..N+8; sel 0..7; done only in N+8; IDLE in N+9.
REQ-031 Scenario MSB-first: MSB_FIRST=1, 8'h81 -> ser_out 1,0,0,0,0,0,0,1; sel 7..0; done with sel=0.
REQ-032 Scenario back-to-back: 8'hFF then 8'h00 with in_valid held high -> 16 contiguous ser_valid cycles (8 ones, then 8 zeros); in_ready high in IDLE and only in cycle 8 of the first frame; two done pulses.
REQ-033 Scenario mid-frame changes: in_data changed to 8'h00 and in_valid pulsed during bit 3 of 8'hFF -> frame remains all ones; no extra frame.
REQ-034 Scenario reset mid-frame: rst during bit 3 -> next cycle ser_valid=0, ser_out=IDLE_LEVEL, in_ready=1, sel=start index, no done.
REQ-035 Scenario idle level: IDLE_LEVEL=1, no traffic for 20 cycles -> ser_out=1, ser_valid=0, done=0 throughout.

Source files
------------

// File: rtl/mux_ser_pkg.sv
// Shared types and widths for the 8-bit mux-based serializer.
package mux_ser_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_8x1.sv
// Plain 8:1 bit multiplexer: out is the input bit addressed by sel.
module mux_8x1
  import mux_ser_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_serializer_8b.sv
// Byte-to-serial converter: latches a byte, then walks an 8:1 mux over it,
// one bit per cycle, with a back-to-back reload on the last bit.
module mux_serializer_8b
  import mux_ser_pkg::*;
#(
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              done
);

  localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic              mux_bit;
  logic              at_last;
  logic              accept;
  logic [SEL_W-1:0]  next_sel;

  assign at_last   = (state == SHIFT) && (sel == LAST_IDX);
  assign in_ready  = (state == IDLE) || at_last;
  assign accept    = in_valid && in_ready;
  assign next_sel  = MSB_FIRST ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
  assign ser_valid = (state == SHIFT);
  assign done      = at_last;
  assign ser_out   = ser_valid ? mux_bit : IDLE_LEVEL;

  mux_8x1 u_mux (
    .in  (hold),
    .sel (sel),
    .out (mux_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= START_IDX;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            hold  <= in_data;
          end
        end
        SHIFT: begin
          if (at_last) begin
            // Last bit: either reload for a gapless next frame or drop to IDLE.
            sel <= START_IDX;
            if (accept) hold  <= in_data;
            else        state <= IDLE;
          end else begin
            sel <= next_sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer_8b.sv
// Self-checking bench: LSB-first/idle-low and MSB-first/idle-high instances
// share one stimulus and are compared against a frame-position reference model.
module tb_mux_serializer_8b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready_l, ser_out_l, ser_valid_l, done_l;
  logic [2:0] sel_l;
  logic       in_ready_m, ser_out_m, ser_valid_m, done_m;
  logic [2:0] sel_m;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_serializer_8b #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_l), .sel(sel_l), .ser_out(ser_out_l),
    .ser_valid(ser_valid_l), .done(done_l)
  );

  mux_serializer_8b #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_m), .sel(sel_m), .ser_out(ser_out_m),
    .ser_valid(ser_valid_m), .done(done_m)
  );

  // Observed vector: {in_ready, sel, ser_out, ser_valid, done}
  logic [6:0] obs_l, obs_m, exp_l, exp_m;
  assign obs_l = {in_ready_l, sel_l, ser_out_l, ser_valid_l, done_l};
  assign obs_m = {in_ready_m, sel_m, ser_out_m, ser_valid_m, done_m};

  // Reference model: is a frame active, which frame bit (0..7) is on the wire,
  // and which byte is being sent.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else if (in_valid && (!m_active || m_k == 7)) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_byte   <= in_data;
    end else if (m_active) begin
      if (m_k == 7) m_active <= 1'b0;
      else          m_k      <= m_k + 1;
    end
  end

  function automatic logic [6:0] expect_vec(input bit msb, input logic idle_lvl);
    int idx;
    idx = msb ? 7 - m_k : m_k;
    if (!m_active) return {1'b1, (msb ? 3'd7 : 3'd0), idle_lvl, 1'b0, 1'b0};
    return {(m_k == 7), 3'(idx), m_byte[idx], 1'b1, (m_k == 7)};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst      = (i < 2);
      in_valid = (i < 2);
      in_data  = 8'h5A;
      @(posedge clk); @(negedge clk);
      exp_l = expect_vec(1'b0, 1'b0);
      exp_m = expect_vec(1'b1, 1'b1);
      checks += 2;
      if (obs_l !== exp_l) begin failures++; $display("FAIL reset_lsb cyc=%0d got=%b exp=%b", i, obs_l, exp_l); end
      if (obs_m !== exp_m) begin failures++; $display("FAIL reset_msb cyc=%0d got=%b exp=%b", i, obs_m, exp_m); end
    end
  endtask

  task automatic test_single_frame(input logic [7:0] data);
    logic [7:0] cap_l, cap_m;
    int done_l_cnt, done_m_cnt;
    cap_l = '0; cap_m = '0; done_l_cnt = 0; done_m_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 0);
      in_data  = (i == 0) ? data : 8'($urandom);
      @(posedge clk); @(negedge clk);
      if (i < 8) begin
        cap_l[i]     = ser_out_l;
        cap_m[7 - i] = ser_out_m;
      end
      done_l_cnt += int'(done_l);
      done_m_cnt += int'(done_m);
      exp_l = expect_vec(1'b0, 1'b0);
      exp_m = expect_vec(1'b1, 1'b1);
      checks += 2;
      if (obs_l !== exp_l) begin failures++; $display("FAIL frame_lsb data=%h cyc=%0d got=%b exp=%b", data, i, obs_l, exp_l); end
      if (obs_m !== exp_m) begin failures++; $display("FAIL frame_msb data=%h cyc=%0d got=%b exp=%b", data, i, obs_m, exp_m); end
    end
    checks += 3;
    if (cap_l !== data) begin failures++; $display("FAIL frame_bits_lsb got=%h exp=%h", cap_l, data); end
    if (cap_m !== data) begin failures++; $display("FAIL frame_bits_msb got=%h exp=%h", cap_m, data); end
    if (done_l_cnt != 1 || done_m_cnt != 1) begin
      failures++; $display("FAIL frame_done_count got=%0d/%0d exp=1/1", done_l_cnt, done_m_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int valid_cnt, ready_cnt, done_cnt, ones_cnt, gap;
    valid_cnt = 0; ready_cnt = 0; done_cnt = 0; ones_cnt = 0; gap = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i <= 8);
      in_data  = (i == 0) ? 8'hFF : 8'h00;
      @(posedge clk); @(negedge clk);
      if (i < 16) begin
        valid_cnt += int'(ser_valid_l);
        ready_cnt += int'(in_ready_l);
        done_cnt  += int'(done_l);
        if (i < 8) ones_cnt += int'(ser_out_l);
        else       ones_cnt += int'(ser_out_l);
        if (!ser_valid_l) gap++;
      end
      exp_l = expect_vec(1'b0, 1'b0);
      exp_m = expect_vec(1'b1, 1'b1);
      checks += 2;
      if (obs_l !== exp_l) begin failures++; $display("FAIL b2b_lsb cyc=%0d got=%b exp=%b", i, obs_l, exp_l); end
      if (obs_m !== exp_m) begin failures++; $display("FAIL b2b_msb cyc=%0d got=%b exp=%b", i, obs_m, exp_m); end
    end
    checks += 4;
    if (valid_cnt != 16 || gap != 0) begin failures++; $display("FAIL b2b_valid got=%0d gaps=%0d exp=16 gaps=0", valid_cnt, gap); end
    if (ready_cnt != 2) begin failures++; $display("FAIL b2b_ready_count got=%0d exp=2", ready_cnt); end
    if (done_cnt != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    if (ones_cnt != 8) begin failures++; $display("FAIL b2b_ones got=%0d exp=8", ones_cnt); end
  endtask

  task automatic test_mid_frame_changes();
    logic [7:0] cap;
    int valid_cnt;
    cap = '0; valid_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i == 0) || (i == 4);
      in_data  = (i == 0) ? 8'hFF : 8'h00;
      @(posedge clk); @(negedge clk);
      if (i < 8) cap[i] = ser_out_l;
      valid_cnt += int'(ser_valid_l);
      exp_l = expect_vec(1'b0, 1'b0);
      exp_m = expect_vec(1'b1, 1'b1);
      checks += 2;
      if (obs_l !== exp_l) begin failures++; $display("FAIL midchg_lsb cyc=%0d got=%b exp=%b", i, obs_l, exp_l); end
      if (obs_m !== exp_m) begin failures++; $display("FAIL midchg_msb cyc=%0d got=%b exp=%b", i, obs_m, exp_m); end
    end
    checks += 2;
    if (cap !== 8'hFF) begin failures++; $display("FAIL midchg_bits got=%h exp=ff", cap); end
    if (valid_cnt != 8) begin failures++; $display("FAIL midchg_valid_count got=%0d exp=8", valid_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int done_cnt, valid_after;
    done_cnt = 0; valid_after = 0;
    for (int i = 0; i < 10; i++) begin
      rst      = (i == 4);
      in_valid = (i == 0);
      in_data  = 8'hFF;
      @(posedge clk); @(negedge clk);
      done_cnt += int'(done_l) + int'(done_m);
      if (i >= 4) valid_after += int'(ser_valid_l) + int'(ser_valid_m);
      exp_l = expect_vec(1'b0, 1'b0);
      exp_m = expect_vec(1'b1, 1'b1);
      checks += 2;
      if (obs_l !== exp_l) begin failures++; $display("FAIL rstmid_lsb cyc=%0d got=%b exp=%b", i, obs_l, exp_l); end
      if (obs_m !== exp_m) begin failures++; $display("FAIL rstmid_msb cyc=%0d got=%b exp=%b", i, obs_m, exp_m); end
    end
    rst = 1'b0;
    checks += 1;
    if (done_cnt != 0 || valid_after != 0) begin
      failures++; $display("FAIL rstmid_abort done=%0d valid_after=%0d exp=0/0", done_cnt, valid_after);
    end
  endtask

  task automatic test_idle_level();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); @(negedge clk);
      if ({ser_out_m, ser_valid_m, done_m} !== 3'b100) bad++;
      exp_l = expect_vec(1'b0, 1'b0);
      exp_m = expect_vec(1'b1, 1'b1);
      checks += 2;
      if (obs_l !== exp_l) begin failures++; $display("FAIL idle_lsb cyc=%0d got=%b exp=%b", i, obs_l, exp_l); end
      if (obs_m !== exp_m) begin failures++; $display("FAIL idle_msb cyc=%0d got=%b exp=%b", i, obs_m, exp_m); end
    end
    checks += 1;
    if (bad != 0) begin failures++; $display("FAIL idle_level_high bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(63) == 0);
      in_valid = ($urandom_range(1) == 1);
      in_data  = 8'($urandom);
      @(posedge clk); @(negedge clk);
      exp_l = expect_vec(1'b0, 1'b0);
      exp_m = expect_vec(1'b1, 1'b1);
      checks += 2;
      if (obs_l !== exp_l) begin failures++; $display("FAIL random_lsb cyc=%0d got=%b exp=%b", i, obs_l, exp_l); end
      if (obs_m !== exp_m) begin failures++; $display("FAIL random_msb cyc=%0d got=%b exp=%b", i, obs_m, exp_m); end
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(8'h81);
    test_single_frame(8'h3C);
    test_back_to_back();
    test_mid_frame_changes();
    test_reset_mid_frame();
    test_idle_level();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
